// File: rtl/load_pkg.sv
// Shared types and constants for the load/writeback path: FSM states,
// load funct3 encodings, fault codes and the accept-time legality checks.
package load_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WB    = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] FLT_NONE     = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
   localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

   function automatic logic f3_legal(input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
      logic mis;
      case (f3)
         F3_LH, F3_LHU: mis = lane[0];
         F3_LW:         mis = (lane != 2'b00);
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a little-endian word and
// sign- or zero-extends it according to the load type.
module load_align
   import load_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // byte and halfword lane selection
   always_comb begin
      byte_s = 8'h00;
      case (lane)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      if (lane[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
   end

   // extension by load type; illegal types never reach writeback
   always_comb begin
      result = 32'h0000_0000;
      case (funct3)
         F3_LB:   result = {{24{byte_s[7]}}, byte_s};
         F3_LBU:  result = {24'h00_0000, byte_s};
         F3_LH:   result = {{16{half_s[15]}}, half_s};
         F3_LHU:  result = {16'h0000, half_s};
         F3_LW:   result = rdata;
         default: result = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/load_writeback_unit.sv
// Multi-cycle load unit: fetches the containing word over a req/gnt/rvalid
// port, aligns/extends it and writes the register file; stalls via ld_ready.
module load_writeback_unit
   import load_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_funct3,
   input  logic [4:0]  ld_rd,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        ld_done,
   output logic        ld_fault,
   output logic [1:0]  ld_fault_code
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_t            state_r;
   logic [31:0]       addr_r;
   logic [2:0]        funct3_r;
   logic [4:0]        rd_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [31:0]       wdata_r;
   logic              ld_ready_r;
   logic              mem_req_r;
   logic              rf_we_r;
   logic              ld_done_r;
   logic              ld_fault_r;
   logic [1:0]        fault_code_r;
   logic [31:0]       aligned_s;

   load_align u_align (
      .rdata  (mem_rdata),
      .lane   (addr_r[1:0]),
      .funct3 (funct3_r),
      .result (aligned_s)
   );

   // load FSM; every output is a register updated alongside the state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         addr_r       <= 32'h0000_0000;
         funct3_r     <= 3'b000;
         rd_r         <= 5'd0;
         cnt_r        <= CNT_ZERO;
         wdata_r      <= 32'h0000_0000;
         ld_ready_r   <= 1'b1;
         mem_req_r    <= 1'b0;
         rf_we_r      <= 1'b0;
         ld_done_r    <= 1'b0;
         ld_fault_r   <= 1'b0;
         fault_code_r <= FLT_NONE;
      end else begin
         rf_we_r      <= 1'b0;
         ld_done_r    <= 1'b0;
         ld_fault_r   <= 1'b0;
         fault_code_r <= FLT_NONE;
         case (state_r)
            ST_IDLE: begin
               if (ld_valid) begin
                  addr_r     <= ld_addr;
                  funct3_r   <= ld_funct3;
                  rd_r       <= ld_rd;
                  ld_ready_r <= 1'b0;
                  // illegal encoding outranks misalignment
                  if (!f3_legal(ld_funct3)) begin
                     state_r      <= ST_FAULT;
                     ld_fault_r   <= 1'b1;
                     fault_code_r <= FLT_ILLEGAL;
                  end else if (f3_misaligned(ld_funct3, ld_addr[1:0])) begin
                     state_r      <= ST_FAULT;
                     ld_fault_r   <= 1'b1;
                     fault_code_r <= FLT_MISALIGN;
                  end else begin
                     state_r   <= ST_REQ;
                     mem_req_r <= 1'b1;
                  end
               end else begin
                  ld_ready_r <= 1'b1;
               end
            end
            ST_REQ: begin
               if (mem_gnt) begin
                  state_r   <= ST_WAIT;
                  mem_req_r <= 1'b0;
                  cnt_r     <= CNT_ZERO;
               end else begin
                  mem_req_r <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  state_r   <= ST_WB;
                  wdata_r   <= aligned_s;
                  rf_we_r   <= (rd_r != 5'd0);
                  ld_done_r <= 1'b1;
               end else if (cnt_r == CNT_LAST) begin
                  state_r      <= ST_FAULT;
                  ld_fault_r   <= 1'b1;
                  fault_code_r <= FLT_TIMEOUT;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_WB: begin
               state_r    <= ST_IDLE;
               ld_ready_r <= 1'b1;
            end
            ST_FAULT: begin
               state_r    <= ST_IDLE;
               ld_ready_r <= 1'b1;
            end
            default: begin
               state_r    <= ST_IDLE;
               ld_ready_r <= 1'b1;
               mem_req_r  <= 1'b0;
            end
         endcase
      end
   end

   assign ld_ready      = ld_ready_r;
   assign mem_req       = mem_req_r;
   assign mem_addr      = {addr_r[31:2], 2'b00};
   assign rf_we         = rf_we_r;
   assign rf_waddr      = rd_r;
   assign rf_wdata      = wdata_r;
   assign ld_done       = ld_done_r;
   assign ld_fault      = ld_fault_r;
   assign ld_fault_code = fault_code_r;

endmodule

// File: doc/load_writeback_unit.md
# load_writeback_unit

Multi-cycle load path for the single-cycle core: accepts one load from the execute stage, fetches the containing word over a request/grant/rvalid memory port, aligns and sign/zero-extends the requested byte/half/word, and drives the register file write port (Reg_WRITE / WRITE_Addr / WRITE_Data). It sits between the ALU address output and the register file, as the writer for the register file's write port, and stalls the core via `ld_ready` while a load is outstanding.

## Interface
- `TIMEOUT`, 64, max WAIT-state cycles without `mem_rvalid` before a timeout fault (≥1).
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `ld_valid` in 1: load request from core.
- `ld_ready` out 1: high only in IDLE; a load is accepted on `ld_valid && ld_ready`.
- `ld_addr` in 32: byte address.
- `ld_funct3` in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal.
- `ld_rd` in 5: destination register.
- `mem_req` out 1: memory read request.
- `mem_addr` out 32: `{addr[31:2], 2'b00}` of the accepted load.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: `mem_rdata` valid.
- `mem_rdata` in 32: little-endian word.
- `rf_we` out 1: register file write enable.
- `rf_waddr` out 5: register file write address.
- `rf_wdata` out 32: register file write data.
- `ld_done` out 1: one-cycle pulse, load completed.
- `ld_fault` out 1: one-cycle pulse, load aborted.
- `ld_fault_code` out 2: 01 misaligned, 10 illegal funct3, 11 timeout; valid only with `ld_fault`, else 00.

## Operation
- States: IDLE, REQ, WAIT, WB, FAULT.
- IDLE: on accept, latch addr, funct3, rd. Illegal funct3 → FAULT code 10. Else misaligned (LH/LHU with addr[0]=1, LW with addr[1:0]≠0) → FAULT code 01. Else → REQ. Illegal funct3 has priority over misalignment.
- REQ: `mem_req`=1, `mem_addr` stable. On `mem_gnt` → WAIT, timeout counter cleared. `mem_rvalid` in REQ is ignored.
- WAIT: on `mem_rvalid`, capture the aligned/extended data → WB. If the counter reaches `TIMEOUT` with no `mem_rvalid` → FAULT code 11. `mem_gnt` is ignored.
- WB: `rf_we`=1 unless rd=0; x0 is never written. `rf_waddr`=rd, `rf_wdata`=result. `ld_done`=1. → IDLE.
- FAULT: `ld_fault`=1 with code, `rf_we`=0 → IDLE.
- Alignment, lane = addr[1:0]:
  - LB/LBU: byte `rdata[8*lane+7 : 8*lane]`.
  - LH/LHU: half `rdata[16*lane[1]+15 : 16*lane[1]]`.
  - LB/LH: sign-extend to 32 bits. LBU/LHU: zero-extend. LW: pass-through.
- Reset (any state, including mid-transaction): → IDLE. All outputs 0 except `ld_ready`=1. Latched fields cleared. A pending memory response after reset is ignored because rvalid is only sampled in WAIT.

## Timing
- Accept at cycle T. `mem_req` from T+1.
- With `mem_gnt` at T+1 and `mem_rvalid` at T+2, `rf_we`/`ld_done` are high at T+3. Minimum latency is 3 cycles, and `ld_ready` returns at T+4.
- Fault detected at accept: `ld_fault` at T+1, `ld_ready` at T+2.
- All outputs are registered or decoded from state only; no combinational input→output paths.
- Timeout fires on the `TIMEOUT`-th consecutive WAIT cycle without rvalid.

## Structure
- Package `load_pkg`:
  - state enum
  - funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`)
  - fault code constants (`FLT_NONE`, `FLT_MISALIGN`, `FLT_ILLEGAL`, `FLT_TIMEOUT`)
- Sub-module `load_align`: combinational; inputs rdata, lane, funct3; output 32-bit extended result.

## Test plan
- LW addr 0x100, rd=5, gnt at T+1, rdata 0xDEADBEEF at T+2 → `mem_addr`=0x100; at T+3 `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, `ld_done`=1.
- LB addr 0x203, rdata 0x80123456 → `rf_wdata`=0xFFFFFF80. LBU same address and data → 0x00000080. LHU addr 0x202 → 0x00008012.
- LH addr 0x101 → `ld_fault`=1, code 01, no `mem_req`, `rf_we` stays 0. funct3=011 → code 10.
- LW rd=0, rdata 0x12345678 → `ld_done`=1, `rf_we`=0.
- TIMEOUT=4: gnt but no rvalid → `ld_fault` code 11 on the 4th WAIT cycle. A late rvalid afterwards causes no write.
- `reset` asserted in WAIT → next cycle IDLE, `ld_ready`=1, all other outputs 0. A following rvalid is ignored, and a new LW then completes normally.
